// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared FSM state type, segment masks, buffer digit codes
// and the nibble-to-glyph lookup used by the seven-segment display block.
package seg_display_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } conv_state_e;

    // Active-high segment masks, bit0 = A .. bit6 = G, bit7 = DOT.
    localparam logic [7:0] SEG_A   = 8'h01;
    localparam logic [7:0] SEG_B   = 8'h02;
    localparam logic [7:0] SEG_C   = 8'h04;
    localparam logic [7:0] SEG_D   = 8'h08;
    localparam logic [7:0] SEG_E   = 8'h10;
    localparam logic [7:0] SEG_F   = 8'h20;
    localparam logic [7:0] SEG_G   = 8'h40;
    localparam logic [7:0] SEG_DOT = 8'h80;

    localparam logic [7:0] GLYPH_MINUS = SEG_G;
    localparam logic [7:0] GLYPH_BLANK = 8'h00;

    // Display buffer digit code: 0..15 is a nibble value, CODE_MINUS is the dash.
    typedef logic [4:0] code_t;
    localparam code_t CODE_MINUS = 5'h10;

    // Decimal digits needed for a DATA_W-bit unsigned magnitude (valid for 4..16).
    function automatic int unsigned bcd_digits(input int unsigned w);
        return (w * 3) / 10 + 1;
    endfunction

    function automatic logic [7:0] glyph_of(input logic [3:0] nibble);
        logic [7:0] g;
        case (nibble)
            4'h0:    g = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
            4'h1:    g = SEG_B | SEG_C;
            4'h2:    g = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
            4'h3:    g = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
            4'h4:    g = SEG_B | SEG_C | SEG_F | SEG_G;
            4'h5:    g = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
            4'h6:    g = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'h7:    g = SEG_A | SEG_B | SEG_C;
            4'h8:    g = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'h9:    g = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
            4'hA:    g = SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G;
            4'hB:    g = SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'hC:    g = SEG_A | SEG_D | SEG_E | SEG_F;
            4'hD:    g = SEG_B | SEG_C | SEG_D | SEG_E | SEG_G;
            4'hE:    g = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G;
            default: g = SEG_A | SEG_E | SEG_F | SEG_G;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_display_if.sv
// seg_display_if: value/mode capture inputs and multiplexed display outputs
// of the seven-segment display block.
interface seg_display_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_DIGITS = 4
);
    logic                  enable;
    logic [DATA_W-1:0]     bus;
    logic                  signed_mode;
    logic                  hex_mode;
    logic [7:0]            segments;
    logic [NUM_DIGITS-1:0] digit;
    logic                  busy;

    modport master (
        output enable, bus, signed_mode, hex_mode,
        input  segments, digit, busy
    );

    modport slave (
        input  enable, bus, signed_mode, hex_mode,
        output segments, digit, busy
    );
endinterface

// File: rtl/seg_bcd_conv.sv
// seg_bcd_conv: capture FSM, one-deep pending request and double-dabble
// binary-to-BCD datapath. Emits a one-cycle write strobe towards the display
// buffer: in DONE for decimal results, or straight from IDLE for hex values.
module seg_bcd_conv
    import seg_display_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                              cpu_clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic [DATA_W-1:0]                 bus,
    input  logic                              signed_mode,
    input  logic                              hex_mode,
    output logic                              busy,
    output logic                              wr,
    output logic                              wr_hex,
    output logic                              wr_neg,
    output logic [4*bcd_digits(DATA_W)-1:0]   wr_val
);
    localparam int unsigned BCD_N = bcd_digits(DATA_W);
    localparam int unsigned BCD_W = 4 * BCD_N;
    localparam int unsigned SR_W  = BCD_W + DATA_W;
    localparam int unsigned CNT_W = $clog2(DATA_W);

    conv_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              neg_q, neg_d;
    logic              pend_valid_q, pend_valid_d;
    logic [DATA_W-1:0] pend_bus_q, pend_bus_d;
    logic              pend_signed_q, pend_signed_d;
    logic              pend_hex_q, pend_hex_d;

    // A live enable always beats a stored pending request (last write wins).
    logic              req_valid, req_signed, req_hex, req_neg;
    logic [DATA_W-1:0] req_bus, req_mag;
    logic [SR_W-1:0]   step_sr;

    assign req_valid  = enable | pend_valid_q;
    assign req_bus    = enable ? bus : pend_bus_q;
    assign req_signed = enable ? signed_mode : pend_signed_q;
    assign req_hex    = enable ? hex_mode : pend_hex_q;
    assign req_neg    = req_signed & req_bus[DATA_W-1];
    // -2^(DATA_W-1) negates to itself, which is the correct unsigned magnitude.
    assign req_mag    = req_neg ? (~req_bus + DATA_W'(1)) : req_bus;
    assign busy       = (state_q != StIdle);

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    always_comb begin
        logic [SR_W-1:0] dab;
        dab = sr_q;
        for (int unsigned k = 0; k < BCD_N; k++) begin
            if (dab[DATA_W + 4*k +: 4] >= 4'd5) begin
                dab[DATA_W + 4*k +: 4] = dab[DATA_W + 4*k +: 4] + 4'd3;
            end
        end
        step_sr = {dab[SR_W-2:0], 1'b0};
    end

    // Next-state, pending register and write-strobe logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sr_d          = sr_q;
        neg_d         = neg_q;
        pend_valid_d  = pend_valid_q;
        pend_bus_d    = pend_bus_q;
        pend_signed_d = pend_signed_q;
        pend_hex_d    = pend_hex_q;
        wr            = 1'b0;
        wr_hex        = 1'b0;
        wr_neg        = neg_q;
        wr_val        = sr_q[SR_W-1:DATA_W];

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    pend_valid_d = 1'b0;
                    if (req_hex) begin
                        wr     = 1'b1;
                        wr_hex = 1'b1;
                        wr_neg = 1'b0;
                        wr_val = BCD_W'(req_bus);
                    end else begin
                        sr_d    = SR_W'(req_mag);
                        neg_d   = req_neg;
                        cnt_d   = '0;
                        state_d = StConv;
                    end
                end
            end
            StConv: begin
                sr_d  = step_sr;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = StDone;
                end
                if (enable) begin
                    pend_valid_d  = 1'b1;
                    pend_bus_d    = bus;
                    pend_signed_d = signed_mode;
                    pend_hex_d    = hex_mode;
                end
            end
            StDone: begin
                wr      = 1'b1;
                state_d = StIdle;
                if (req_valid) begin
                    if (req_hex) begin
                        // The write port is taken this cycle; IDLE replays the hex request.
                        if (enable) begin
                            pend_valid_d  = 1'b1;
                            pend_bus_d    = bus;
                            pend_signed_d = signed_mode;
                            pend_hex_d    = hex_mode;
                        end
                    end else begin
                        pend_valid_d = 1'b0;
                        sr_d         = SR_W'(req_mag);
                        neg_d        = req_neg;
                        cnt_d        = '0;
                        state_d      = StConv;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            sr_q          <= '0;
            neg_q         <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_bus_q    <= '0;
            pend_signed_q <= 1'b0;
            pend_hex_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sr_q          <= sr_d;
            neg_q         <= neg_d;
            pend_valid_q  <= pend_valid_d;
            pend_bus_q    <= pend_bus_d;
            pend_signed_q <= pend_signed_d;
            pend_hex_q    <= pend_hex_d;
        end
    end

endmodule

// File: rtl/seg_display_mux.sv
// seg_display_mux: multiplexed seven-segment display of a captured bus value
// in decimal (optionally signed) or hex. Holds the display buffer, overflow
// and minus placement, leading-zero blanking, refresh prescaler and the
// registered segment/digit outputs.
// Build option: define SEG_DISPLAY_LZB_EN to blank leading zero digits.
module seg_display_mux
    import seg_display_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 1024
) (
    input logic        cpu_clk,
    input logic        rst,
    seg_display_if.slave dsp
);
    localparam int unsigned BCD_W   = 4 * bcd_digits(DATA_W);
    localparam int unsigned EXT_W   = (BCD_W > 4 * NUM_DIGITS) ? BCD_W : 4 * NUM_DIGITS;
    localparam int unsigned EXT_N   = EXT_W / 4;
    localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

    logic             conv_busy, wr, wr_hex, wr_neg;
    logic [BCD_W-1:0] wr_val;

    seg_bcd_conv #(
        .DATA_W (DATA_W)
    ) u_conv (
        .cpu_clk     (cpu_clk),
        .rst         (rst),
        .enable      (dsp.enable),
        .bus         (dsp.bus),
        .signed_mode (dsp.signed_mode),
        .hex_mode    (dsp.hex_mode),
        .busy        (conv_busy),
        .wr          (wr),
        .wr_hex      (wr_hex),
        .wr_neg      (wr_neg),
        .wr_val      (wr_val)
    );

    code_t                 buf_q [NUM_DIGITS];
    code_t                 buf_d [NUM_DIGITS];
    logic [EXT_W-1:0]      val_ext;
    int unsigned           cap;
    logic                  ovf;
    logic [NUM_DIGITS-1:0] blank;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] digit_q, digit_d;
    logic [7:0]            seg_q, seg_d;
    logic                  tc;
    code_t                 sel_code;

    // Buffer update: decimal results with minus/overflow handling, or raw hex nibbles.
    always_comb begin
        buf_d   = buf_q;
        val_ext = EXT_W'(wr_val);
        cap     = wr_neg ? NUM_DIGITS - 1 : NUM_DIGITS;
        ovf     = 1'b0;
        for (int unsigned k = 0; k < EXT_N; k++) begin
            if (k >= cap && val_ext[4*k +: 4] != 4'd0) begin
                ovf = 1'b1;
            end
        end
        if (wr) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (!wr_hex && ovf) begin
                    buf_d[i] = CODE_MINUS;
                end else if (!wr_hex && wr_neg && i == NUM_DIGITS - 1) begin
                    buf_d[i] = CODE_MINUS;
                end else begin
                    buf_d[i] = {1'b0, val_ext[4*i +: 4]};
                end
            end
        end
    end

    // Leading-zero blanking over the next buffer contents; digit 0 always shows.
    always_comb begin
        blank = '0;
`ifdef SEG_DISPLAY_LZB_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                if (i != 0 && lead && buf_d[i] == 5'd0) begin
                    blank[i] = 1'b1;
                end
                // A leading minus sign does not end the run of leading zeros.
                lead = lead && (buf_d[i] == 5'd0 || buf_d[i] == CODE_MINUS);
            end
        end
`else
        blank = '0;
`endif
    end

    // Refresh scan and glyph select for the digit that is selected after this edge.
    always_comb begin
        tc       = (presc_q == PRESC_W'(REFRESH_DIV - 1));
        presc_d  = tc ? '0 : presc_q + 1'b1;
        idx_d    = idx_q;
        digit_d  = digit_q;
        if (tc) begin
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            digit_d = {digit_q[NUM_DIGITS-2:0], digit_q[NUM_DIGITS-1]};
        end
        sel_code = buf_d[idx_d];
        if (blank[idx_d]) begin
            seg_d = GLYPH_BLANK;
        end else if (sel_code == CODE_MINUS) begin
            seg_d = GLYPH_MINUS;
        end else begin
            seg_d = glyph_of(sel_code[3:0]);
        end
        seg_d = seg_d & ~SEG_DOT;
    end

    // Buffer, scan and output registers; segments and digit update on the same edge.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            buf_q   <= '{default: '0};
            presc_q <= '0;
            idx_q   <= '0;
            digit_q <= NUM_DIGITS'(1);
            seg_q   <= glyph_of(4'h0);
        end else begin
            buf_q   <= buf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
        end
    end

    assign dsp.segments = seg_q;
    assign dsp.digit    = digit_q;
    assign dsp.busy     = conv_busy;

endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: directed checks of seg_display_mux with an 8-bit and a
// 16-bit instance (4 digits, refresh every 4 cycles).
module tb_seg_display_mux;

    logic cpu_clk = 1'b0;
    logic rst;

    always #5 cpu_clk = ~cpu_clk;

    seg_display_if #(.DATA_W(8),  .NUM_DIGITS(4)) dif ();
    seg_display_if #(.DATA_W(16), .NUM_DIGITS(4)) dif16 ();

    seg_display_mux #(.DATA_W(8), .NUM_DIGITS(4), .REFRESH_DIV(4)) u_dut (
        .cpu_clk (cpu_clk),
        .rst     (rst),
        .dsp     (dif)
    );

    seg_display_mux #(.DATA_W(16), .NUM_DIGITS(4), .REFRESH_DIV(4)) u_dut16 (
        .cpu_clk (cpu_clk),
        .rst     (rst),
        .dsp     (dif16)
    );

    // Expected digits 3..0, packed as {d3, d2, d1, d0}.
`ifdef SEG_DISPLAY_LZB_EN
    localparam logic [31:0] EXP_RESET = 32'h0000003F;
    localparam logic [31:0] EXP_123   = 32'h00065B4F;
    localparam logic [31:0] EXP_F6    = 32'h4000063F;
    localparam logic [31:0] EXP_80    = 32'h40065B7F;
    localparam logic [31:0] EXP_7F    = 32'h00065B07;
    localparam logic [31:0] EXP_255   = 32'h005B6D6D;
    localparam logic [31:0] EXP_AF    = 32'h00007771;
    localparam logic [31:0] EXP_9     = 32'h0000006F;
`else
    localparam logic [31:0] EXP_RESET = 32'h3F3F3F3F;
    localparam logic [31:0] EXP_123   = 32'h3F065B4F;
    localparam logic [31:0] EXP_F6    = 32'h403F063F;
    localparam logic [31:0] EXP_80    = 32'h40065B7F;
    localparam logic [31:0] EXP_7F    = 32'h3F065B07;
    localparam logic [31:0] EXP_255   = 32'h3F5B6D6D;
    localparam logic [31:0] EXP_AF    = 32'h3F3F7771;
    localparam logic [31:0] EXP_9     = 32'h3F3F3F6F;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture one value, then count the cycles busy stays high (bounded).
    task automatic send(input bit w16, input logic [15:0] val, input logic sgn,
                        input logic hx, output int nb);
        int  guard;
        logic b;
        @(negedge cpu_clk);
        if (w16) begin
            dif16.bus = val; dif16.signed_mode = sgn; dif16.hex_mode = hx; dif16.enable = 1'b1;
        end else begin
            dif.bus = val[7:0]; dif.signed_mode = sgn; dif.hex_mode = hx; dif.enable = 1'b1;
        end
        @(negedge cpu_clk);
        dif.enable   = 1'b0;
        dif16.enable = 1'b0;
        b  = w16 ? dif16.busy : dif.busy;
        nb = b ? 1 : 0;
        guard = 0;
        do begin
            @(negedge cpu_clk);
            guard++;
            b = w16 ? dif16.busy : dif.busy;
            if (b) nb++;
        end while (b && guard < 100);
    endtask

    // Collect the glyph shown for each digit select as the scan comes round.
    task automatic read_disp(input bit w16, output logic [31:0] segs);
        logic [3:0] sel;
        int         guard;
        bit         found;
        segs = 'x;
        for (int d = 0; d < 4; d++) begin
            found = 1'b0;
            guard = 0;
            while (!found && guard < 64) begin
                @(negedge cpu_clk);
                guard++;
                sel = w16 ? dif16.digit : dif.digit;
                if (sel == 4'(1 << d)) begin
                    found = 1'b1;
                    segs[8*d +: 8] = w16 ? dif16.segments : dif.segments;
                end
            end
            if (!found) check("digit_select_timeout", {31'd0, found}, 32'd1);
        end
    endtask

    logic [31:0] segs;
    logic [31:0] exp_v;
    logic [3:0]  prev;
    int          nb;
    int          guard;
    int          slot;
    bit          found;
    bit          saw7;

    initial begin
        dif.enable   = 1'b0; dif.bus   = '0; dif.signed_mode   = 1'b0; dif.hex_mode   = 1'b0;
        dif16.enable = 1'b0; dif16.bus = '0; dif16.signed_mode = 1'b0; dif16.hex_mode = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge cpu_clk);
        check("rst_busy",    {31'd0, dif.busy}, 32'd0);
        check("rst_digit",   {28'd0, dif.digit}, 32'h1);
        check("rst_seg",     {24'd0, dif.segments}, 32'h3F);
        check("rst_busy16",  {31'd0, dif16.busy}, 32'd0);
        rst = 1'b0;

        read_disp(1'b0, segs);
        check("reset_display", segs, EXP_RESET);

        send(1'b0, 16'd123, 1'b0, 1'b0, nb);
        check("busy_cycles_123", nb, 9);
        read_disp(1'b0, segs);
        check("dec_123", segs, EXP_123);

        // Refresh: sync on the 1000 -> 0001 wrap, then follow the scan cycle by cycle.
        exp_v = EXP_123;
        prev  = dif.digit;
        found = 1'b0;
        guard = 0;
        while (!found && guard < 64) begin
            @(negedge cpu_clk);
            guard++;
            if (prev == 4'b1000 && dif.digit == 4'b0001) found = 1'b1;
            prev = dif.digit;
        end
        check("refresh_sync", {31'd0, found}, 32'd1);
        for (int k = 0; k < 17; k++) begin
            if (k > 0) @(negedge cpu_clk);
            slot = (k / 4) % 4;
            check("refresh_digit", {28'd0, dif.digit}, 32'(1 << slot));
            check("refresh_seg", {24'd0, dif.segments}, {24'd0, exp_v[8*slot +: 8]});
        end

        send(1'b0, 16'h00F6, 1'b1, 1'b0, nb);
        check("busy_cycles_neg10", nb, 9);
        read_disp(1'b0, segs);
        check("signed_neg10", segs, EXP_F6);

        send(1'b0, 16'h0080, 1'b1, 1'b0, nb);
        read_disp(1'b0, segs);
        check("signed_min_neg128", segs, EXP_80);

        send(1'b0, 16'h007F, 1'b1, 1'b0, nb);
        read_disp(1'b0, segs);
        check("signed_pos127", segs, EXP_7F);

        send(1'b0, 16'h00FF, 1'b0, 1'b0, nb);
        read_disp(1'b0, segs);
        check("unsigned_255", segs, EXP_255);

        send(1'b0, 16'h00AF, 1'b0, 1'b1, nb);
        check("hex_busy_cycles", nb, 0);
        read_disp(1'b0, segs);
        check("hex_AF", segs, EXP_AF);

        // Three captures during one conversion: 5 converts, 7 is overwritten by 9.
        saw7 = 1'b0;
        @(negedge cpu_clk);
        dif.bus = 8'd5; dif.signed_mode = 1'b0; dif.hex_mode = 1'b0; dif.enable = 1'b1;
        @(negedge cpu_clk);
        nb = dif.busy ? 1 : 0;
        dif.bus = 8'd7;
        @(negedge cpu_clk);
        nb += dif.busy ? 1 : 0;
        dif.bus = 8'd9;
        @(negedge cpu_clk);
        nb += dif.busy ? 1 : 0;
        dif.enable = 1'b0;
        guard = 0;
        do begin
            @(negedge cpu_clk);
            guard++;
            if (dif.busy) nb++;
            if (dif.digit == 4'b0001 && dif.segments == 8'h07) saw7 = 1'b1;
        end while (dif.busy && guard < 100);
        check("pending_busy_cycles", nb, 18);
        read_disp(1'b0, segs);
        check("pending_last_wins", segs, EXP_9);
        check("pending_7_never_shown", {31'd0, saw7}, 32'd0);

        // Reset in the middle of a conversion leaves the reset display.
        @(negedge cpu_clk);
        dif.bus = 8'd42; dif.enable = 1'b1;
        @(negedge cpu_clk);
        dif.enable = 1'b0;
        repeat (3) @(negedge cpu_clk);
        check("midconv_busy", {31'd0, dif.busy}, 32'd1);
        rst = 1'b1;
        @(negedge cpu_clk);
        check("midconv_rst_busy",  {31'd0, dif.busy}, 32'd0);
        check("midconv_rst_digit", {28'd0, dif.digit}, 32'h1);
        check("midconv_rst_seg",   {24'd0, dif.segments}, 32'h3F);
        rst = 1'b0;
        repeat (12) @(negedge cpu_clk);
        check("midconv_idle_after", {31'd0, dif.busy}, 32'd0);
        read_disp(1'b0, segs);
        check("midconv_no_partial", segs, EXP_RESET);

        send(1'b1, 16'd12345, 1'b0, 1'b0, nb);
        check("busy_cycles_w16", nb, 17);
        read_disp(1'b1, segs);
        check("w16_overflow_12345", segs, 32'h40404040);

        send(1'b1, 16'd9999, 1'b0, 1'b0, nb);
        read_disp(1'b1, segs);
        check("w16_9999", segs, 32'h6F6F6F6F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 Parameter DATA_W, default 8: width of the bus value; legal range 4..16.
REQ-002 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 2..8.
REQ-003 Parameter REFRESH_DIV, default 1024: cpu_clk cycles per digit slot; minimum 2.
REQ-004 cpu_clk  in  1  block clock; all state is on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  when high at a cpu_clk edge, capture bus as the new display value.
REQ-007 bus  in  DATA_W  value to display.
REQ-008 signed_mode  in  1  treat the captured value as two's complement; sampled together with bus.
REQ-009 hex_mode  in  1  show the value as hex nibbles instead of decimal; sampled together with bus.
REQ-010 segments  out  8  active-high segment drive; bit0=A .. bit6=G, bit7=DOT.
REQ-011 digit  out  NUM_DIGITS  one-hot, active-high (common cathode) digit select; bit0 is the least-significant digit.
REQ-012 busy  out  1  high while a conversion is in progress.

Function
REQ-013 Converter FSM states: IDLE, CONV, DONE.
REQ-014 IDLE + enable, decimal: latch magnitude and sign flag, clear the BCD shift register, go to CONV.
REQ-015 CONV: one double-dabble step per cycle (add 3 to every BCD nibble >=5, then shift left one bit); exactly DATA_W cycles, then DONE.
REQ-016 DONE: write the display buffer for one cycle, then IDLE; the buffer changes DATA_W+1 edges after the capture edge.
REQ-017 IDLE + enable, hex_mode=1: write nibbles straight to the display buffer on the next edge, no CONV; buffer digits above ceil(DATA_W/4) show 0.
REQ-018 busy is high in CONV and DONE, low in IDLE.
REQ-019 enable while busy: store bus/mode in a one-deep pending register (last write wins); DONE then goes to conversion of the pending value instead of IDLE.
REQ-020 signed_mode=1 with MSB set: convert the two's-complement magnitude (-2^(DATA_W-1) is handled with a DATA_W-bit magnitude); the most-significant digit shows minus (0x40).
REQ-021 Capacity is NUM_DIGITS decimal digits, or NUM_DIGITS-1 when a minus sign is shown; a nonzero BCD digit beyond capacity sets overflow, and every digit then shows 0x40.
REQ-022 Glyphs: 0-9 = 3F 06 5B 4F 66 6D 7D 07 7F 6F; A-F = 77 7C 39 5E 79 71; blank=00; DOT is always 0.
REQ-023 Refresh: a prescaler counts 0..REFRESH_DIV-1; at terminal count the digit index increments mod NUM_DIGITS and digit rotates left by one, wrapping from MSB to bit0.
REQ-024 segments is registered with digit, so the glyph and its select change on the same edge; there is never a cycle of mismatch.
REQ-025 The display buffer only changes in DONE or on a hex write, so the refresh never shows a partly converted value.

Reset
REQ-026 rst asserted: FSM to IDLE, busy=0, pending cleared, display buffer all 0 (the reset glyph is 0x3F on every digit, or per REQ-030).
REQ-027 rst asserted: prescaler=0, digit index=0, digit=1 (bit0 set), segments=glyph of buffer digit 0.
REQ-028 rst asserted mid-conversion: the conversion is abandoned and no partial result is written.

Configuration
REQ-029 Macro SEG_DISPLAY_LZB_EN selects leading-zero blanking.
REQ-030 With SEG_DISPLAY_LZB_EN: zero digits above the highest nonzero digit show blank (0x00); digit 0 is never blanked; the minus sign stays on the most-significant digit; overflow dashes are not blanked.
REQ-031 Without SEG_DISPLAY_LZB_EN: all digits show their value, including leading zeros.

Structure
REQ-032 Package seg_display_pkg holds: FSM state enum, segment bit constants, glyph constants (minus, blank), and function glyph_of(nibble).
REQ-033 Sub-module seg_bcd_conv holds the FSM, pending register and double-dabble datapath; the top holds the buffer, blanking, prescaler and output mux.

Verification (DATA_W=8, NUM_DIGITS=4, REFRESH_DIV=4 unless stated; macro off unless stated)
REQ-034 bus=123, enable for 1 cycle -> busy high for 9 cycles; digits 3..0 = 3F 06 5B 4F; with SEG_DISPLAY_LZB_EN, digit3 = 00.
REQ-035 bus=8'hF6, signed_mode=1 -> digits 3..0 = 40 3F 06 3F; bus=8'h80 -> 40 06 5B 7F.
REQ-036 bus=8'hAF, hex_mode=1 -> busy stays 0; buffer updated next edge; digits 3..0 = 3F 3F 77 71.
REQ-037 DATA_W=16, bus=12345 -> all digits 40; bus=9999 -> 6F 6F 6F 6F.
REQ-038 enable 5 then 7 then 9 during one CONV -> 5 is shown, then 9; 7 is never shown; busy stays high until 9 is done; rst pulse during CONV -> all digits 3F, digit=0001.
REQ-039 Refresh -> digit goes 0001,0010,0100,1000,0001 every 4 cycles, and segments always match the selected digit.
